mr_chips_trace: RTL and testbench
=================================

# mr_chips_trace

Execution-trace capture block for the mr_chips core. It observes the core's `pc_out` and `alu_result` buses, records one (PC, ALU result) pair each time the PC changes, and buffers the pairs in a FIFO. A host or debug reader drains the FIFO through a valid/ready handshake, so runs can be checked in hardware without waveform dumps.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, at least 2.
- `W`, 16: width of the PC and ALU fields; matches the core buses.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `pc_in`  in  W  connected to the core's `pc_out`.
- `alu_in`  in  W  connected to the core's `alu_result`.
- `capture_en`  in  1  enables capture when 1; when 0 nothing is recorded.
- `clear`  in  1  synchronous flush of the FIFO and status.
- `trace_valid`  out  1  the FIFO head entry is available.
- `trace_ready`  in  1  the reader accepts the head entry.
- `trace_pc`  out  W  PC field of the head entry.
- `trace_alu`  out  W  ALU field of the head entry.
- `count`  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- `overflow`  out  1  sticky flag: at least one capture was dropped.
- `drop_count`  out  8  number of dropped captures, saturates at 255.

## Operation
- Internal state:
  - `last_pc` (W bits) and `last_vld` (1 bit): the last PC that was captured.
  - Storage array, `wr_ptr`, `rd_ptr`, `count`.
- Capture condition `cap`: `capture_en` AND (NOT `last_vld` OR `pc_in` != `last_pc`).
  - The first enabled cycle after reset or clear always captures.
  - A repeated PC is not recorded twice. This includes a stalled PC and the stretch while the core is held in reset.
- On a clock edge with `cap` = 1:
  - `last_pc` <= `pc_in` and `last_vld` <= 1, whether the push succeeds or is dropped.
  - Push {`pc_in`, `alu_in`} if the FIFO is not full, or if it is full and a pop happens on the same edge.
  - Otherwise drop the capture: `overflow` <= 1 and `drop_count` increments, saturating at 255.
- Pop: on an edge with `trace_valid` = 1 AND `trace_ready` = 1, `rd_ptr` advances.
  - `trace_ready` while `trace_valid` = 0 has no effect.
- Occupancy update:
  - push only: `count` + 1.
  - pop only: `count` - 1.
  - push and pop together: `count` unchanged.
- Pointers wrap modulo `DEPTH`.
- `clear` = 1 has priority over push and pop on the same edge. It sets `count`, both pointers, `overflow`, `drop_count` and `last_vld` to 0. Storage contents are don't-care.
- Changing `capture_en` never disturbs FIFO contents or the reader side.

## Timing
- Reset values, applied asynchronously while `reset` = 0:
  - `trace_valid` = 0, `count` = 0, `overflow` = 0, `drop_count` = 0.
  - `trace_pc` = 0, `trace_alu` = 0.
  - `last_vld` = 0, both pointers 0.
- Reset deassertion is synchronous to `clk`. The first capture can occur on the first edge after `reset` goes high.
- `trace_valid` = (`count` != 0). `trace_pc` and `trace_alu` come from storage at `rd_ptr` and are forced to 0 when `count` = 0.
- Latency: if `cap` = 1 before edge N with the FIFO empty, `trace_valid` = 1 after edge N and shows that entry. That is one cycle, with no fall-through within the same cycle.
- Throughput: one capture and one pop per cycle sustained.
- Full (`count` = `DEPTH`):
  - A push without a same-edge pop is dropped.
  - A push with a same-edge pop is accepted, and the new entry lands at the old `rd_ptr` slot position modulo `DEPTH`.
- Empty: a pop is impossible because `trace_valid` = 0.
- Reset asserted mid-transfer: all entries are discarded immediately, and `trace_valid` falls without waiting for a clock.
- Outputs change only on `clk` edges or on reset assertion.

## Test plan
- Reset and first capture:
  - Stimulus: hold `reset` = 0 and check all outputs are 0. Release reset with `capture_en` = 1, `pc_in` = 0x0000, `alu_in` = 0x0005.
  - Required: one edge later `trace_valid` = 1, `trace_pc` = 0x0000, `trace_alu` = 0x0005, `count` = 1.
- Deduplication:
  - Stimulus: `pc_in` sequence 0x0002, 0x0002, 0x0002, 0x0004 with `trace_ready` = 0.
  - Required: exactly 2 entries, (0x0002, ...) then (0x0004, ...), and `count` = 2.
- Overflow:
  - Stimulus: `DEPTH` = 16, `trace_ready` = 0, 20 distinct PCs 0x0000..0x0013.
  - Required: `count` = 16, `overflow` = 1, `drop_count` = 4. Draining returns 0x0000..0x000F in order, then `trace_valid` = 0.
- Full with simultaneous push and pop:
  - Stimulus: FIFO full; on one edge `trace_ready` = 1 and a new PC 0x00AA is presented.
  - Required: `count` stays 16, `drop_count` is unchanged, and 0x00AA is the last entry drained.
- Clear priority and async reset:
  - Stimulus: assert `clear` with 5 entries held and a push and pop on the same edge.
  - Required: after the edge `count` = 0, `overflow` = 0, and the next PC is captured even if it equals the pre-clear `last_pc`.
  - Stimulus: drop `reset` mid-cycle.
  - Required: `trace_valid` = 0 before the next edge.
- Core integration:
  - Stimulus: attach to mr_chips, 100 ns reset, then 1500 ns of run while draining continuously.
  - Required: the drained PC sequence matches `pc_out` transitions one-for-one, with `overflow` = 0.

Source files
------------

// File: rtl/mr_chips_trace.sv
// Execution-trace capture for the mr_chips core: records (PC, ALU result) on each
// PC change into a FIFO that a reader drains through a valid/ready handshake.
module mr_chips_trace #(
  parameter int DEPTH = 16,
  parameter int W     = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [W-1:0]             pc_in,
  input  logic [W-1:0]             alu_in,
  input  logic                     capture_en,
  input  logic                     clear,
  output logic                     trace_valid,
  input  logic                     trace_ready,
  output logic [W-1:0]             trace_pc,
  output logic [W-1:0]             trace_alu,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [7:0]               drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  pc_mem  [DEPTH];
  logic [W-1:0]  alu_mem [DEPTH];

  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          overflow_reg;
  logic [7:0]    drop_count_reg;
  logic [W-1:0]  last_pc_reg;
  logic          last_vld_reg;

  logic cap, full, pop, push, drop;

  // A stalled PC (including one frozen while the core sits in reset) is recorded once.
  assign cap  = capture_en && (!last_vld_reg || (pc_in != last_pc_reg));
  assign full = (count_reg == CW'(DEPTH));
  assign pop  = trace_valid && trace_ready;
  assign push = cap && (!full || pop);
  assign drop = cap && !push;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      overflow_reg   <= 1'b0;
      drop_count_reg <= '0;
      last_pc_reg    <= '0;
      last_vld_reg   <= 1'b0;
    end else if (clear) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      overflow_reg   <= 1'b0;
      drop_count_reg <= '0;
      last_vld_reg   <= 1'b0;
    end else begin
      if (cap) begin
        last_pc_reg  <= pc_in;
        last_vld_reg <= 1'b1;
      end
      if (push)
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      if (drop) begin
        overflow_reg <= 1'b1;
        if (drop_count_reg != 8'hFF)
          drop_count_reg <= drop_count_reg + 8'd1;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // When full with a same-edge pop, wr_ptr equals the old rd_ptr, so the new entry
  // reuses the slot being vacated.
  always_ff @(posedge clk) begin
    if (push && !clear) begin
      pc_mem[wr_ptr_reg]  <= pc_in;
      alu_mem[wr_ptr_reg] <= alu_in;
    end
  end

  assign trace_valid = (count_reg != '0);
  assign trace_pc    = trace_valid ? pc_mem[rd_ptr_reg]  : '0;
  assign trace_alu   = trace_valid ? alu_mem[rd_ptr_reg] : '0;
  assign count       = count_reg;
  assign overflow    = overflow_reg;
  assign drop_count  = drop_count_reg;

endmodule

// File: tb/tb_mr_chips_trace.sv
// Scoreboard bench for mr_chips_trace: stimulus queues expected entries, a negedge
// monitor checks every accepted pop against the queue head.
module tb_mr_chips_trace;

  localparam int DEPTH = 16;
  localparam int W     = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [W-1:0]  pc_in = '0;
  logic [W-1:0]  alu_in = '0;
  logic          capture_en = 1'b0;
  logic          clear = 1'b0;
  logic          trace_valid;
  logic          trace_ready = 1'b0;
  logic [W-1:0]  trace_pc;
  logic [W-1:0]  trace_alu;
  logic [4:0]    count;
  logic          overflow;
  logic [7:0]    drop_count;

  int total = 0;
  int bad   = 0;
  logic [2*W-1:0] exp_q[$];

  mr_chips_trace #(.DEPTH(DEPTH), .W(W)) dut (
    .clk(clk), .reset(reset), .pc_in(pc_in), .alu_in(alu_in),
    .capture_en(capture_en), .clear(clear), .trace_valid(trace_valid),
    .trace_ready(trace_ready), .trace_pc(trace_pc), .trace_alu(trace_alu),
    .count(count), .overflow(overflow), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end else
      $display("ok   %s: %h", name, act);
  endtask

  // Inputs settle 1 ns after a rising edge; this advances exactly one edge.
  task automatic step(input logic en, input logic rdy, input logic [W-1:0] pc,
                      input logic [W-1:0] alu);
    capture_en  = en;
    trace_ready = rdy;
    pc_in       = pc;
    alu_in      = alu;
    @(posedge clk);
    #1;
  endtask

  // Monitor: an entry shown with valid & ready at mid-cycle is popped on the next edge.
  always @(negedge clk) begin
    if (reset && !clear && trace_valid && trace_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL pop: unexpected entry pc=%h alu=%h (queue empty)", trace_pc, trace_alu);
      end else begin
        logic [2*W-1:0] e;
        e = exp_q.pop_front();
        check("pop", {trace_pc, trace_alu}, e);
      end
    end
  end

  initial begin
    // Reset state
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_valid", trace_valid, 0);
    check("rst_count", count, 0);
    check("rst_ovf",   overflow, 0);
    check("rst_drop",  drop_count, 0);
    check("rst_pc",    trace_pc, 0);
    check("rst_alu",   trace_alu, 0);

    // First capture one edge after reset release
    capture_en = 1'b1; pc_in = 16'h0000; alu_in = 16'h0005;
    reset = 1'b1;
    exp_q.push_back({16'h0000, 16'h0005});
    @(posedge clk); #1;
    check("first_valid", trace_valid, 1);
    check("first_pc",    trace_pc, 16'h0000);
    check("first_alu",   trace_alu, 16'h0005);
    check("first_count", count, 1);
    step(1'b1, 1'b0, 16'h0000, 16'h0006);
    check("stall_count", count, 1);
    step(1'b0, 1'b1, 16'h0000, 16'h0000);
    check("drain1_count", count, 0);

    // Deduplication
    exp_q.push_back({16'h0002, 16'h0011});
    exp_q.push_back({16'h0004, 16'h0014});
    step(1'b1, 1'b0, 16'h0002, 16'h0011);
    step(1'b1, 1'b0, 16'h0002, 16'h0012);
    step(1'b1, 1'b0, 16'h0002, 16'h0013);
    step(1'b1, 1'b0, 16'h0004, 16'h0014);
    check("dedup_count", count, 2);
    step(1'b0, 1'b1, 16'h0000, 16'h0000);
    step(1'b0, 1'b1, 16'h0000, 16'h0000);
    check("dedup_empty", trace_valid, 0);
    // Ready while empty does nothing
    step(1'b0, 1'b1, 16'h0000, 16'h0000);
    check("empty_ready_count", count, 0);

    // Overflow: 20 distinct PCs into 16 slots
    for (int i = 0; i < 20; i++) begin
      if (i < DEPTH) exp_q.push_back({16'(i), 16'(i) ^ 16'h5A00});
      step(1'b1, 1'b0, 16'(i), 16'(i) ^ 16'h5A00);
    end
    check("ovf_count", count, 16);
    check("ovf_flag",  overflow, 1);
    check("ovf_drop",  drop_count, 4);

    // Full with same-edge push and pop: 0x00AA goes in, head 0x0000 comes out
    exp_q.push_back({16'h00AA, 16'h00BB});
    step(1'b1, 1'b1, 16'h00AA, 16'h00BB);
    check("fullpp_count", count, 16);
    check("fullpp_drop",  drop_count, 4);
    for (int i = 0; i < DEPTH; i++)
      step(1'b0, 1'b1, 16'h0000, 16'h0000);
    check("fullpp_empty", trace_valid, 0);
    check("fullpp_q",     exp_q.size(), 0);

    // Clear priority over push and pop
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back({16'h0030 + 16'(i), 16'h0100 + 16'(i)});
      step(1'b1, 1'b0, 16'h0030 + 16'(i), 16'h0100 + 16'(i));
    end
    check("clr_pre_count", count, 5);
    clear = 1'b1;
    step(1'b1, 1'b1, 16'h0035, 16'h0135);
    clear = 1'b0;
    exp_q.delete();
    check("clr_count", count, 0);
    check("clr_ovf",   overflow, 0);
    check("clr_drop",  drop_count, 0);
    // Same PC as before clear must still be captured
    exp_q.push_back({16'h0034, 16'h0077});
    step(1'b1, 1'b0, 16'h0034, 16'h0077);
    check("clr_recap_count", count, 1);
    check("clr_recap_pc", trace_pc, 16'h0034);

    // Async reset mid-cycle
    #2 reset = 1'b0;
    #1;
    check("arst_valid", trace_valid, 0);
    check("arst_count", count, 0);
    exp_q.delete();
    capture_en = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;

    // Core-like run with stalls and a branch back, draining continuously
    begin
      logic [W-1:0] pcs [12];
      logic [W-1:0] prev;
      logic         have;
      pcs = '{16'h0100, 16'h0102, 16'h0102, 16'h0104, 16'h0106, 16'h0106,
              16'h0106, 16'h0100, 16'h0102, 16'h0108, 16'h010A, 16'h010A};
      have = 1'b0;
      prev = '0;
      for (int i = 0; i < 12; i++) begin
        if (!have || pcs[i] != prev)
          exp_q.push_back({pcs[i], pcs[i] ^ 16'hFFFF});
        have = 1'b1;
        prev = pcs[i];
        step(1'b1, 1'b1, pcs[i], pcs[i] ^ 16'hFFFF);
      end
      for (int i = 0; i < 4; i++)
        step(1'b0, 1'b1, 16'h0000, 16'h0000);
    end
    check("run_ovf",   overflow, 0);
    check("run_empty", trace_valid, 0);
    check("run_q",     exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not end in time");
    $fatal(1, "timeout");
  end

endmodule
